// File: rtl/addsub_rr_arbiter_pkg.sv
// Shared types for the round-robin add/sub arbiter and its environment.
package addsub_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int MAX_ID_W   = 3;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  // One response beat; sized for the widest supported requester count.
  typedef struct packed {
    logic [MAX_ID_W-1:0]   id;
    logic [DEF_DATA_W-1:0] a;
    logic [DEF_DATA_W-1:0] b;
    logic [DEF_DATA_W:0]   sum;
    logic [DEF_DATA_W-1:0] diff;
  } addsub_rsp_t;

endpackage

// File: rtl/addsub_rr_arbiter_if.sv
// Request/response bundle between requesters, the arbiter and the consumer.
interface addsub_rr_arbiter_if
  import addsub_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_a;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_b;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [ID_W-1:0]                rsp_id;
  logic [DATA_W-1:0]              rsp_a;
  logic [DATA_W-1:0]              rsp_b;
  logic [DATA_W:0]                rsp_sum;
  logic [DATA_W-1:0]              rsp_diff;

  // Requesters plus result consumer side.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_a, rsp_b, rsp_sum, rsp_diff
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_a, rsp_b, rsp_sum, rsp_diff
  );
endinterface

// File: rtl/addsub_rr_arbiter_rr.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any
);
  int idx;

  // Scan NUM_REQ candidates starting at ptr; the first hit wins.
  always_comb begin
    grant  = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        gnt_id     = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/addsub_rr_arbiter.sv
// Shares one add/sub datapath among NUM_REQ requesters, one op in flight.
module addsub_rr_arbiter
  import addsub_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  addsub_rr_arbiter_if.slave  bus,
  output logic                busy
);
  state_e            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr, lat_id;
  logic [DATA_W-1:0] lat_a, lat_b;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]   gnt_id;
  logic              any;
  logic              rsp_valid_c, busy_c, take;

  logic [ID_W-1:0]   rsp_id;
  logic [DATA_W-1:0] rsp_a, rsp_b, rsp_diff;
  logic [DATA_W:0]   rsp_sum;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req    (bus.req_valid),
    .ptr    (rr_ptr),
    .grant  (grant),
    .gnt_id (gnt_id),
    .any    (any)
  );

  // Next state and status outputs.
  always_comb begin
    state_nxt   = state;
    rsp_valid_c = 1'b0;
    busy_c      = 1'b1;
    take        = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        take   = any;
        if (any) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant only from IDLE; held low while reset is asserted even if requests are up.
  assign bus.req_ready = (take && rst_n) ? grant : '0;
  assign bus.rsp_valid = rsp_valid_c;
  assign busy          = busy_c;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_a     = rsp_a;
  assign bus.rsp_b     = rsp_b;
  assign bus.rsp_sum   = rsp_sum;
  assign bus.rsp_diff  = rsp_diff;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Capture the winner's id and operands on the grant edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_id <= '0;
      lat_a  <= '0;
      lat_b  <= '0;
    end else if (take) begin
      lat_id <= gnt_id;
      lat_a  <= bus.req_a[gnt_id];
      lat_b  <= bus.req_b[gnt_id];
    end
  end

  // Compute and present the result; values persist through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id   <= '0;
      rsp_a    <= '0;
      rsp_b    <= '0;
      rsp_sum  <= '0;
      rsp_diff <= '0;
    end else if (state == EXEC) begin
      rsp_id   <= lat_id;
      rsp_a    <= lat_a;
      rsp_b    <= lat_b;
      rsp_sum  <= {1'b0, lat_a} + {1'b0, lat_b};
      rsp_diff <= lat_a - lat_b;
    end
  end

  // Priority moves just past the requester whose response was accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr <= '0;
    else if (state == RESP && bus.rsp_ready)
      rr_ptr <= (lat_id == ID_W'(NUM_REQ - 1)) ? '0 : lat_id + 1'b1;
  end
endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Bench for addsub_rr_arbiter: directed vectors plus a cycle model and scoreboard.
module tb_addsub_rr_arbiter;
  localparam int N = 4;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  always #5 clk = ~clk;

  addsub_rr_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();
  addsub_rr_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q [N][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_phase = 0;  // 0 waiting for a request, 1 computing, 2 offering result
  int m_ptr = 0, m_id = 0, w = -1;
  int m_a = 0, m_b = 0;
  int e_id = 0, e_a = 0, e_b = 0, e_sum = 0, e_diff = 0;
  int wait_cnt [N];
  logic [N-1:0] exp_rdy;
  logic [W-1:0] qa, qb;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_ptr = 0;
      e_id = 0; e_a = 0; e_b = 0; e_sum = 0; e_diff = 0;
      for (int k = 0; k < N; k++) begin wait_cnt[k] = 0; exp_q[k].delete(); end
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_data", {bus.rsp_id, bus.rsp_a, bus.rsp_b, bus.rsp_sum, bus.rsp_diff}, 0);
    end else begin
      exp_rdy = '0; w = -1;
      if (m_phase == 0)
        for (int k = 0; k < N; k++)
          if (w < 0 && bus.req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", bus.req_ready, exp_rdy);
      chk("busy", busy, m_phase != 0);
      chk("rsp_valid", bus.rsp_valid, m_phase == 2);
      chk("rsp_id", bus.rsp_id, e_id);
      chk("rsp_a", bus.rsp_a, e_a);
      chk("rsp_b", bus.rsp_b, e_b);
      chk("rsp_sum", bus.rsp_sum, e_sum);
      chk("rsp_diff", bus.rsp_diff, e_diff);
      // Scoreboard: each accepted response must match the oldest op of that requester.
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q[bus.rsp_id].size() == 0) chk("sb_unexpected_rsp", bus.rsp_id, 99);
        else begin
          {qa, qb} = exp_q[bus.rsp_id].pop_front();
          chk("sb_a", bus.rsp_a, qa);
          chk("sb_b", bus.rsp_b, qb);
          chk("sb_sum", bus.rsp_sum, int'(qa) + int'(qb));
          chk("sb_diff", bus.rsp_diff, (int'(qa) - int'(qb) + (1 << W)) % (1 << W));
        end
      end
      case (m_phase)
        0: if (w >= 0) begin
          for (int k = 0; k < N; k++) begin
            if (k == w) wait_cnt[k] = 0;
            else if (bus.req_valid[k]) begin
              wait_cnt[k]++;
              chk("max_wait", wait_cnt[k] <= N - 1, 1);
            end else wait_cnt[k] = 0;
          end
          m_id = w; m_a = int'(bus.req_a[w]); m_b = int'(bus.req_b[w]);
          m_phase = 1;
        end
        1: begin
          e_id = m_id; e_a = m_a; e_b = m_b;
          e_sum = m_a + m_b;
          e_diff = (m_a - m_b + (1 << W)) % (1 << W);
          m_phase = 2;
        end
        default: if (bus.rsp_ready) begin
          m_ptr = (m_id + 1) % N;
          m_phase = 0;
        end
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic raise(input int i, input int a, input int b);
    bus.req_valid[i] = 1'b1;
    bus.req_a[i] = W'(a);
    bus.req_b[i] = W'(b);
    exp_q[i].push_back({W'(a), W'(b)});
  endtask

  task automatic wait_grant(input int i);
    int t = 0;
    do begin @(negedge clk); t++; end while (!bus.req_ready[i] && t < 50);
    chk("grant_seen", bus.req_ready[i], 1);
    @(posedge clk); #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp();
    int t = 0;
    do begin @(negedge clk); t++; end while (!bus.rsp_valid && t < 50);
    chk("rsp_seen", bus.rsp_valid, 1);
  endtask

  task automatic run_op(input int i, input int a, input int b,
                        output int id, output int s, output int d);
    @(posedge clk); #1;
    raise(i, a, b);
    wait_grant(i);
    wait_rsp();
    id = int'(bus.rsp_id); s = int'(bus.rsp_sum); d = int'(bus.rsp_diff);
    @(posedge clk); #1;
  endtask

  function automatic bit q_empty();
    for (int k = 0; k < N; k++) if (exp_q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain();
    int t = 0;
    logic [N-1:0] acc;
    bus.rsp_ready = 1'b1;
    while ((bus.req_valid != 0 || !q_empty() || busy) && t < 500) begin
      @(negedge clk); acc = bus.req_ready;
      @(posedge clk); #1; t++;
      bus.req_valid = bus.req_valid & ~acc;
    end
    chk("drain_done", t < 500, 1);
  endtask

  // ---------------- directed + random sequence ----------------
  int rid, rs, rd, g, t, issued, cyc;
  int order [5];
  int exp_order [5] = '{0, 1, 2, 3, 0};
  logic [N-1:0] acc;

  initial begin
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_sum", bus.rsp_sum, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single op from requester 0: grant at T, result at T+2.
    raise(0, 9, 1); bus.rsp_ready = 1'b1;
    @(negedge clk); chk("single_grant", bus.req_ready, 4'b0001);
    @(posedge clk); #1 bus.req_valid[0] = 1'b0;
    @(negedge clk); chk("single_exec_valid", bus.rsp_valid, 0);
    @(negedge clk);
    chk("single_valid", bus.rsp_valid, 1);
    chk("single_id", bus.rsp_id, 0);
    chk("single_sum", bus.rsp_sum, 10);
    chk("single_diff", bus.rsp_diff, 8);
    @(negedge clk); chk("single_done", bus.rsp_valid, 0);

    // Arithmetic corners.
    run_op(1, 15, 15, rid, rs, rd); chk("ovf_sum", rs, 30); chk("ovf_id", rid, 1);
    run_op(2, 1, 2, rid, rs, rd);   chk("wrap_diff", rd, 15);
    run_op(3, 7, 7, rid, rs, rd);   chk("eq_diff", rd, 0); chk("eq_sum", rs, 14);

    // Backpressure: result held, no grants while stalled.
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1 raise(2, 5, 3);
    wait_grant(2);
    raise(1, 4, 6);
    wait_rsp();
    repeat (5) begin
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_id", bus.rsp_id, 2);
      chk("bp_sum", bus.rsp_sum, 8);
      chk("bp_diff", bus.rsp_diff, 2);
      chk("bp_ready", bus.req_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(negedge clk); chk("bp_last_valid", bus.rsp_valid, 1);
    @(negedge clk);
    chk("bp_after_valid", bus.rsp_valid, 0);
    chk("bp_next_grant", bus.req_ready, 4'b0010);
    @(posedge clk); #1 bus.req_valid[1] = 1'b0;
    wait_rsp();
    chk("bp2_sum", bus.rsp_sum, 10);
    chk("bp2_diff", bus.rsp_diff, 14);
    @(posedge clk); #1;

    // Reset while a result is being offered.
    bus.rsp_ready = 1'b0;
    raise(2, 3, 3);
    wait_grant(2);
    wait_rsp();
    #2; bus.req_valid = '1; rst_n = 1'b0;
    #1;
    chk("rstmid_valid", bus.rsp_valid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_ready", bus.req_ready, 0);
    @(posedge clk); @(posedge clk); #1;
    bus.req_valid = '0; rst_n = 1'b1; bus.rsp_ready = 1'b1;

    // Round robin with everyone continuously requesting.
    for (int k = 0; k < N; k++) raise(k, k + 1, 2 * k);
    for (int k = 0; k < 5; k++) order[k] = -1;
    g = 0; t = 0;
    while (g < 5 && t < 100) begin
      @(negedge clk); t++;
      if (bus.req_ready != 0) begin
        for (int k = 0; k < N; k++) if (bus.req_ready[k]) rid = k;
        order[g] = rid; g++;
        @(posedge clk); #1 raise(rid, 15 - rid - g, rid + g);
      end
    end
    for (int k = 0; k < 5; k++) chk($sformatf("rr_order%0d", k), order[k], exp_order[k]);
    drain();

    // Random traffic.
    issued = 0; cyc = 0;
    while ((issued < 200 || bus.req_valid != 0) && cyc < 8000) begin
      @(negedge clk); acc = bus.req_ready;
      @(posedge clk); #1; cyc++;
      bus.req_valid = bus.req_valid & ~acc;
      for (int k = 0; k < N; k++)
        if (!bus.req_valid[k] && issued < 200 && $urandom_range(0, 2) == 0) begin
          raise(k, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
          issued++;
        end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    chk("rand_issued", issued, 200);
    drain();
    @(negedge clk); chk("final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/addsub_rr_arbiter.md
Name: addsub_rr_arbiter

Overview:
- Shares one 4-bit add/sub datapath (sum = a+b, 5-bit; diff = a-b, 4-bit wrap) between NUM_REQ requesters.
- Round-robin arbitration, per-requester valid/ready request handshake, single valid/ready response channel tagged with the winner id.
- Sits between stimulus/agent requesters and a shared checker/scoreboard; one operation in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 4, operand width; sum is DATA_W+1, diff is DATA_W.
- ID_W, $clog2(NUM_REQ), width of rsp_id.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester grant/accept; at most one bit high.
- req_a  input  NUM_REQ*DATA_W  packed operand a; slice i belongs to requester i.
- req_b  input  NUM_REQ*DATA_W  packed operand b; slice i belongs to requester i.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  downstream accepts result.
- rsp_id  output  ID_W  index of the requester that owns the result.
- rsp_a, rsp_b  output  DATA_W  echoed operands.
- rsp_sum  output  DATA_W+1  a+b, zero-extended, no overflow loss.
- rsp_diff  output  DATA_W  (a-b) mod 2^DATA_W.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; rr_ptr=0; all outputs 0 (req_ready, rsp_valid, rsp_id, rsp_a, rsp_b, rsp_sum, rsp_diff, busy).
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational. The winner is the first set bit of req_valid, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - If any request is valid, req_ready[winner]=1 in the same cycle. On that edge, latch winner id, a and b slices; go to EXEC.
  - If no request is valid, stay in IDLE.
- EXEC (1 cycle): register rsp_sum=a+b and rsp_diff=a-b. Drive rsp_id, rsp_a, rsp_b from the latch. Go to RESP.
- RESP:
  - rsp_valid=1; outputs held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid drops next cycle; rr_ptr=(winner+1) mod NUM_REQ; go to IDLE.
- Latency: grant at cycle T gives rsp_valid at T+2. Minimum issue interval is 3 cycles (back-to-back rsp_ready=1).
- Ownership after grant: a requester must hold req_valid and operands until its req_ready. Non-granted requesters keep waiting; no request is dropped.
- req_ready is 0 in EXEC and RESP (backpressure to all requesters).
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,... A requester waits at most NUM_REQ-1 grants.
- Arithmetic:
  - sum: DATA_W+1 bits, e.g. 15+15=30 (5'b11110).
  - diff: wraps, e.g. 1-2=4'b1111 (15); a==b gives 0.
- Simultaneous events:
  - A request arriving in the cycle RESP completes is seen in the following IDLE cycle.
  - rsp_ready high before rsp_valid has no effect.
- Reset mid-operation: any in-flight op is discarded with no response; rr_ptr returns to 0.
- rsp_* data outputs keep their last values in IDLE; only rsp_valid qualifies them.

Decomposition:
- Package addsub_pkg:
  - DATA_W default constant.
  - typedef state_e {IDLE, EXEC, RESP}.
  - typedef addsub_rsp_t struct {id, a, b, sum, diff} for bench reuse.
- Sub-module rr_arbiter: a purely combinational round-robin priority picker (inputs req, ptr; outputs grant one-hot, gnt_id, any).
- The FSM and datapath registers stay in addsub_rr_arbiter.

Test Plan:
- Reset: rst_n=0 mid-RESP → rsp_valid, req_ready, busy go 0 immediately; after release, first grant goes to requester 0.
- Single op: req_valid=4'b0001, a=9, b=1, rsp_ready=1 → req_ready[0] at T; at T+2 rsp_valid=1, id=0, sum=10 (5'b01010), diff=8.
- Wrap/overflow: a=15, b=15 → sum=30; a=1, b=2 → diff=15; a=7, b=7 → diff=0.
- Round-robin: all four valid continuously, rsp_ready=1 → grant order 0,1,2,3,0; each response id matches its echoed operands.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_* stable, req_ready=0 for all requesters; rsp_ready=1 → one handshake, then IDLE.
- Random: 200 ops with random valids, operands and rsp_ready → scoreboard matches sum/diff per id; no lost or duplicate grants; max wait ≤ 3 grants.
